// File: rtl/fir_tap_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fir_tap_sequencer_if
//  Brief    : Handshake, sample-RAM and MAC control bundle of the FIR sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface fir_tap_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic              wr_zero;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] coef_addr;
    logic              acc_clr;
    logic              acc_en;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    modport master (
        input  flush, in_valid, out_ready,
        output in_ready, wr_en, wr_zero, wr_addr, rd_addr, coef_addr,
               acc_clr, acc_en, out_valid, busy
    );

    modport slave (
        output flush, in_valid, out_ready,
        input  in_ready, wr_en, wr_zero, wr_addr, rd_addr, coef_addr,
               acc_clr, acc_en, out_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/fir_tap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fir_tap_sequencer
//  Brief    : Control FSM for a time-multiplexed FIR: circular sample RAM
//             writes, per-tap MAC addressing, drain and output handshake.
//  Revision : 1.0  initial release
// ============================================================================
module fir_tap_sequencer #(
    parameter int NTAPS   = 16,
    parameter int ADDR_W  = 4,
    parameter int MAC_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fir_tap_sequencer_if.master  bus
);
    localparam int c_CNT_MAX = (NTAPS > MAC_LAT) ? NTAPS : MAC_LAT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_CLR_LAST   = c_CNT_W'(NTAPS - 1);
    localparam logic [c_CNT_W-1:0] c_DRAIN_LAST = c_CNT_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);
    localparam logic [ADDR_W-1:0]  c_TAP_LAST   = ADDR_W'(NTAPS - 1);

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_CLR   = 3'd1,
        ST_IDLE  = 3'd2,
        ST_MAC   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_OUT   = 3'd5
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_head, r_newest, r_tap;
    logic [ADDR_W-1:0]   w_head_nxt, w_newest_nxt, w_tap_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;

    logic                w_in_ready, w_wr_en, w_wr_zero;
    logic [ADDR_W-1:0]   w_wr_addr, w_rd_addr, w_coef_addr;
    logic                w_acc_clr, w_acc_en, w_out_valid, w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_RST;
            r_head   <= '0;
            r_newest <= '0;
            r_tap    <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_head   <= w_head_nxt;
            r_newest <= w_newest_nxt;
            r_tap    <= w_tap_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_head_nxt   = r_head;
        w_newest_nxt = r_newest;
        w_tap_nxt    = r_tap;
        w_cnt_nxt    = r_cnt;
        w_in_ready   = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_zero    = 1'b0;
        w_wr_addr    = '0;
        w_rd_addr    = '0;
        w_coef_addr  = '0;
        w_acc_clr    = 1'b0;
        w_acc_en     = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = (r_state != ST_IDLE);

        case (r_state)
            ST_RST: begin
                w_state_nxt = ST_CLR;
                w_cnt_nxt   = '0;
            end
            ST_CLR: begin
                w_wr_en   = 1'b1;
                w_wr_zero = 1'b1;
                w_wr_addr = r_cnt[ADDR_W-1:0];
                if (r_cnt == c_CLR_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_head_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            ST_IDLE: begin
                w_in_ready = 1'b1;
                // A sample arriving together with flush takes priority.
                if (bus.in_valid) begin
                    w_wr_en      = 1'b1;
                    w_wr_addr    = r_head;
                    w_newest_nxt = r_head;
                    w_head_nxt   = r_head + ADDR_W'(1);
                    w_tap_nxt    = '0;
                    w_state_nxt  = ST_MAC;
                end else if (bus.flush) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_CLR;
                end
            end
            ST_MAC: begin
                w_acc_en    = 1'b1;
                w_acc_clr   = (r_tap == '0);
                w_coef_addr = r_tap;
                w_rd_addr   = r_newest - r_tap;
                w_tap_nxt   = r_tap + ADDR_W'(1);
                if (r_tap == c_TAP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (MAC_LAT == 0) ? ST_OUT : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == c_DRAIN_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_OUT;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            ST_OUT: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_RST;
            end
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.wr_en     = w_wr_en;
    assign bus.wr_zero   = w_wr_zero;
    assign bus.wr_addr   = w_wr_addr;
    assign bus.rd_addr   = w_rd_addr;
    assign bus.coef_addr = w_coef_addr;
    assign bus.acc_clr   = w_acc_clr;
    assign bus.acc_en    = w_acc_en;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_fir_tap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_tap_sequencer
//  Brief    : Directed-random bench for fir_tap_sequencer against a
//             transaction-level model of sample placement and tap order.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_tap_sequencer;
    localparam int NTAPS   = 16;
    localparam int ADDR_W  = 4;
    localparam int MAC_LAT = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fir_tap_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    fir_tap_sequencer #(
        .NTAPS   (NTAPS),
        .ADDR_W  (ADDR_W),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    // Reference model: number of samples written since the RAM was last zeroed.
    int model_written = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects the current cycle to be the first of a full RAM clear.
    task automatic check_clear();
        for (int i = 0; i < NTAPS; i++) begin
            #1;
            chk("clr_wr_en",     32'(bus.wr_en),     32'd1);
            chk("clr_wr_zero",   32'(bus.wr_zero),   32'd1);
            chk("clr_wr_addr",   32'(bus.wr_addr),   32'(i));
            chk("clr_in_ready",  32'(bus.in_ready),  32'd0);
            chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
            chk("clr_acc_en",    32'(bus.acc_en),    32'd0);
            tick();
        end
        #1;
        chk("post_clr_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_clr_busy",     32'(bus.busy),     32'd0);
        model_written = 0;
    endtask

    task automatic check_rst_outputs(input string tag);
        chk({tag, "_busy"},      32'(bus.busy),      32'd1);
        chk({tag, "_wr_en"},     32'(bus.wr_en),     32'd0);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
        chk({tag, "_acc_en"},    32'(bus.acc_en),    32'd0);
        chk({tag, "_acc_clr"},   32'(bus.acc_clr),   32'd0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_rd_addr"},   32'(bus.rd_addr),   32'd0);
        chk({tag, "_coef_addr"}, 32'(bus.coef_addr), 32'd0);
    endtask

    // Drive rst_n low now, release it one edge later, then expect a clear.
    task automatic reset_and_clear(input string tag);
        rst_n = 1'b0;
        #1;
        check_rst_outputs(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_rst_outputs({tag, "_held"});
        tick();
        check_clear();
    endtask

    task automatic accept_sample(input bit with_flush, output int wa);
        wa = model_written % NTAPS;
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
            in_idle_step();
        end
        bus.in_valid = 1'b1;
        bus.flush    = with_flush;
        #1;
        chk("acc_wr_en",   32'(bus.wr_en),   32'd1);
        chk("acc_wr_zero", 32'(bus.wr_zero), 32'd0);
        chk("acc_wr_addr", 32'(bus.wr_addr), 32'(wa));
        tick();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        model_written++;
    endtask

    task automatic in_idle_step();
        bus.in_valid = 1'b0;
        #1;
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        chk("idle_wr_en",    32'(bus.wr_en),    32'd0);
        tick();
    endtask

    task automatic mac_step(input int wa, input int k);
        // Stray requests during the tap sweep must have no effect.
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.flush    = 1'($urandom_range(0, 1));
        #1;
        chk("mac_acc_en",    32'(bus.acc_en),    32'd1);
        chk("mac_acc_clr",   32'(bus.acc_clr),   32'(k == 0));
        chk("mac_coef_addr", 32'(bus.coef_addr), 32'(k));
        chk("mac_rd_addr",   32'(bus.rd_addr),   32'((wa - k + NTAPS) % NTAPS));
        chk("mac_in_ready",  32'(bus.in_ready),  32'd0);
        chk("mac_wr_en",     32'(bus.wr_en),     32'd0);
        chk("mac_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic run_sample(input bit with_flush, input int bp);
        int wa;
        accept_sample(with_flush, wa);
        for (int k = 0; k < NTAPS; k++) mac_step(wa, k);
        for (int d = 0; d < MAC_LAT; d++) begin
            #1;
            chk("drain_acc_en",    32'(bus.acc_en),    32'd0);
            chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
            chk("drain_busy",      32'(bus.busy),      32'd1);
            tick();
        end
        bus.out_ready = 1'b0;
        for (int b = 0; b < bp; b++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            #1;
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
            chk("bp_wr_en",     32'(bus.wr_en),     32'd0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("hs_out_valid", 32'(bus.out_valid), 32'd1);
        chk("hs_in_ready",  32'(bus.in_ready),  32'd0);
        tick();
        bus.out_ready = 1'b0;
        #1;
        chk("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
        chk("post_hs_in_ready",  32'(bus.in_ready),  32'd1);
    endtask

    task automatic flush_idle();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        #1;
        chk("flush_wr_en",    32'(bus.wr_en),    32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.flush = 1'b0;
        check_clear();
    endtask

    task automatic reset_mid_mac();
        int wa;
        accept_sample(1'b0, wa);
        for (int k = 0; k < 7; k++) mac_step(wa, k);
        #1;
        chk("tap7_coef_addr", 32'(bus.coef_addr), 32'd7);
        #1;
        reset_and_clear("midrst");
    endtask

    initial begin
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        reset_and_clear("rst");

        // Impulse with immediate downstream acceptance, then a run past wrap.
        run_sample(1'b0, 0);
        for (int i = 0; i < 17; i++) begin
            run_sample(1'b0, (i == 3) ? 5 : int'($urandom_range(0, 3)));
        end

        flush_idle();
        run_sample(1'b1, 0);
        run_sample(1'b0, 1);

        for (int i = 0; i < 12; i++) begin
            int r;
            r = int'($urandom_range(0, 3));
            if (r == 0) flush_idle();
            else        run_sample(r == 1, int'($urandom_range(0, 5)));
        end

        reset_mid_mac();
        run_sample(1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
